// File: rtl/dac7611_rx.sv
// DAC7611-style serial receiver: synchronised 3-wire frame capture, LD/CLR latch control.
// Optional frame-error counter port err_count enabled by defining DAC7611_RX_ERRCNT_EN.
module dac7611_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dac_cs,
  input  logic        dac_clk,
  input  logic        dac_sdi,
  input  logic        dac_ld,
  input  logic        dac_clr,
  output logic [11:0] code,
  output logic        code_valid,
  output logic        frame_err,
  output logic        busy
`ifdef DAC7611_RX_ERRCNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_HOLD
  } state_t;

  logic [SYNC_STAGES-1:0] r_cs_sync, r_clk_sync, r_sdi_sync, r_ld_sync, r_clr_sync;
  logic                   r_clk_prev, r_ld_prev, r_clr_prev;
  logic                   w_cs, w_sclk, w_sdi, w_ld, w_clr;
  logic                   w_clk_rise, w_ld_fall, w_clr_fall;

  state_t      r_state, w_state_nxt;
  logic [11:0] r_shreg, r_inreg;
  logic [3:0]  r_cnt;
  logic        w_start, w_shift, w_capture, w_ld_load, w_err;

  // Synchronisers reset to the idle level of each pin so no spurious edges follow reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cs_sync  <= '1;
      r_clk_sync <= '0;
      r_sdi_sync <= '0;
      r_ld_sync  <= '1;
      r_clr_sync <= '1;
      r_clk_prev <= 1'b0;
      r_ld_prev  <= 1'b1;
      r_clr_prev <= 1'b1;
    end else begin
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], dac_cs};
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], dac_clk};
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], dac_sdi};
      r_ld_sync  <= {r_ld_sync[SYNC_STAGES-2:0], dac_ld};
      r_clr_sync <= {r_clr_sync[SYNC_STAGES-2:0], dac_clr};
      r_clk_prev <= w_sclk;
      r_ld_prev  <= w_ld;
      r_clr_prev <= w_clr;
    end
  end

  assign w_cs       = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk     = r_clk_sync[SYNC_STAGES-1];
  assign w_sdi      = r_sdi_sync[SYNC_STAGES-1];
  assign w_ld       = r_ld_sync[SYNC_STAGES-1];
  assign w_clr      = r_clr_sync[SYNC_STAGES-1];
  assign w_clk_rise = w_sclk & ~r_clk_prev;
  assign w_ld_fall  = ~w_ld & r_ld_prev;
  assign w_clr_fall = ~w_clr & r_clr_prev;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_capture   = 1'b0;
    w_ld_load   = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ld_load = w_ld_fall;
        if (!w_cs) begin
          w_state_nxt = ST_SHIFT;
          w_start     = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_cs) begin
          if (r_cnt == 4'd12) begin
            w_state_nxt = ST_HOLD;
            w_capture   = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_err       = 1'b1;
          end
        end else if (w_clk_rise) begin
          w_shift = 1'b1;
        end
        if (w_ld_fall) w_err = 1'b1;
      end
      ST_HOLD: begin
        if (w_ld_fall) begin
          w_state_nxt = ST_IDLE;
          w_ld_load   = 1'b1;
        end else if (!w_cs) begin
          w_state_nxt = ST_SHIFT;
          w_start     = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // CLR low dominates both the input register and the latch, masking any LD load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg    <= '0;
      r_cnt      <= '0;
      r_inreg    <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= w_err;
      if (w_start) begin
        r_shreg <= '0;
        r_cnt   <= '0;
      end else if (w_shift) begin
        r_shreg <= {r_shreg[10:0], w_sdi};
        if (r_cnt != 4'd15) r_cnt <= r_cnt + 4'd1;
      end
      if (!w_clr) begin
        r_inreg    <= '0;
        code       <= '0;
        code_valid <= w_clr_fall;
      end else begin
        if (w_capture) r_inreg <= r_shreg;
        if (w_ld_load) begin
          code       <= r_inreg;
          code_valid <= 1'b1;
        end
      end
    end
  end

  assign busy = (r_state == ST_SHIFT);

`ifdef DAC7611_RX_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (reset)                            err_count <= '0;
    else if (w_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_dac7611_rx.sv
// Self-checking bench for dac7611_rx: directed scenarios plus randomized frames vs. a transaction-level model.
// Defining DAC7611_RX_ERRCNT_EN also exercises the err_count port.
module tb_dac7611_rx;
  localparam int S  = 2;
  localparam int HC = S + 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        dac_cs, dac_clk, dac_sdi, dac_ld, dac_clr;
  logic [11:0] code;
  logic        code_valid, frame_err, busy;
`ifdef DAC7611_RX_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  int checks = 0;
  int errors = 0;
  int cv_cnt = 0;
  int fe_cnt = 0;
  logic [11:0] m_inreg, m_code;

  dac7611_rx #(.SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .dac_cs(dac_cs), .dac_clk(dac_clk), .dac_sdi(dac_sdi),
    .dac_ld(dac_ld), .dac_clr(dac_clr), .code(code), .code_valid(code_valid),
    .frame_err(frame_err), .busy(busy)
`ifdef DAC7611_RX_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (code_valid === 1'b1) cv_cnt++;
    if (frame_err === 1'b1)  fe_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_pins;
    dac_cs = 1'b1; dac_clk = 1'b0; dac_sdi = 1'b0; dac_ld = 1'b1; dac_clr = 1'b1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    idle_pins();
    wait_cyc(S + 3);
    reset = 1'b0;
    wait_cyc(2);
    m_inreg = '0;
    m_code  = '0;
  endtask

  task automatic pulse_ld;
    dac_ld = 1'b0;
    wait_cyc(HC);
    dac_ld = 1'b1;
    wait_cyc(HC);
  endtask

  // Full pin-level frame; model: a frame of exactly 12 clocks replaces the input register.
  task automatic send_frame(input logic [11:0] data, input int nbits, input bit mid_ld);
    dac_cs = 1'b0;
    wait_cyc(HC);
    for (int i = 0; i < nbits; i++) begin
      dac_sdi = (i < 12) ? data[11 - i] : 1'b0;
      wait_cyc(HC);
      dac_clk = 1'b1;
      wait_cyc(HC);
      dac_clk = 1'b0;
      if (i == 0) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_in_frame: got %b want 1", busy);
        end
      end
      if (mid_ld && i == 2) pulse_ld();
    end
    wait_cyc(HC);
    dac_cs  = 1'b1;
    dac_sdi = 1'b0;
    wait_cyc(S + 3);
    if (nbits == 12 && dac_clr) m_inreg = data;
  endtask

  task automatic test_reset;
    int cv0, fe0;
    do_reset();
    cv0 = cv_cnt; fe0 = fe_cnt;
    wait_cyc(20);
    checks++;
    if (code !== 12'h000) begin errors++; $display("FAIL reset_code: got %h want 000", code); end
    checks++;
    if (cv_cnt != cv0) begin errors++; $display("FAIL reset_cv: got %0d pulses want 0", cv_cnt - cv0); end
    checks++;
    if (fe_cnt != fe0) begin errors++; $display("FAIL reset_fe: got %0d pulses want 0", fe_cnt - fe0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_load_latency;
    int first, npulse;
    send_frame(12'hA5C, 12, 1'b0);
    checks++;
    if (code !== 12'h000) begin errors++; $display("FAIL frame_no_load: got %h want 000", code); end
    first = -1; npulse = 0;
    dac_ld = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      wait_cyc(1);
      if (code_valid === 1'b1) begin
        npulse++;
        if (first < 0) first = k;
      end
    end
    dac_ld = 1'b1;
    wait_cyc(HC);
    m_code = m_inreg;
    checks++;
    if (first != S + 1) begin errors++; $display("FAIL ld_latency: got %0d cycles want %0d", first, S + 1); end
    checks++;
    if (npulse != 1) begin errors++; $display("FAIL ld_pulse_count: got %0d want 1", npulse); end
    checks++;
    if (code !== 12'hA5C) begin errors++; $display("FAIL ld_code: got %h want a5c", code); end
  endtask

  task automatic test_short_frame;
    int cv0, fe0;
    fe0 = fe_cnt;
    send_frame(12'h3C3, 11, 1'b0);
    checks++;
    if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL short_fe: got %0d pulses want 1", fe_cnt - fe0); end
    cv0 = cv_cnt;
    pulse_ld();
    checks++;
    if (code !== m_code) begin errors++; $display("FAIL short_reload: got %h want %h", code, m_code); end
    checks++;
    if (cv_cnt - cv0 != 1) begin errors++; $display("FAIL short_reload_cv: got %0d want 1", cv_cnt - cv0); end
  endtask

  task automatic test_clear;
    int cv0;
    send_frame(12'hFFF, 12, 1'b0);
    pulse_ld();
    m_code = m_inreg;
    checks++;
    if (code !== 12'hFFF) begin errors++; $display("FAIL clr_preload: got %h want fff", code); end
    cv0 = cv_cnt;
    dac_clr = 1'b0;
    wait_cyc(S + 4);
    m_inreg = '0; m_code = '0;
    checks++;
    if (code !== 12'h000) begin errors++; $display("FAIL clr_code: got %h want 000", code); end
    checks++;
    if (cv_cnt - cv0 != 1) begin errors++; $display("FAIL clr_cv: got %0d want 1", cv_cnt - cv0); end
    pulse_ld();
    checks++;
    if (code !== 12'h000) begin errors++; $display("FAIL clr_ld_override: got %h want 000", code); end
    checks++;
    if (cv_cnt - cv0 != 1) begin errors++; $display("FAIL clr_ld_cv: got %0d want 1", cv_cnt - cv0); end
    dac_clr = 1'b1;
    wait_cyc(S + 3);
    pulse_ld();
    checks++;
    if (code !== 12'h000) begin errors++; $display("FAIL clr_inreg_cleared: got %h want 000", code); end
  endtask

  task automatic test_reset_midframe;
    int fe0;
    logic [11:0] d;
    d = 12'h123;
    fe0 = fe_cnt;
    dac_cs = 1'b0;
    wait_cyc(HC);
    for (int i = 0; i < 6; i++) begin
      dac_sdi = d[11 - i];
      wait_cyc(HC);
      dac_clk = 1'b1;
      wait_cyc(HC);
      dac_clk = 1'b0;
    end
    reset = 1'b1;
    wait_cyc(1);
    idle_pins();
    wait_cyc(S + 3);
    reset = 1'b0;
    m_inreg = '0; m_code = '0;
    wait_cyc(S + 3);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset_idle: busy got %b want 0", busy); end
    checks++;
    if (code !== 12'h000) begin errors++; $display("FAIL midreset_code: got %h want 000", code); end
    checks++;
    if (fe_cnt != fe0) begin errors++; $display("FAIL midreset_fe: got %0d pulses want 0", fe_cnt - fe0); end
    send_frame(12'h456, 12, 1'b0);
    pulse_ld();
    m_code = m_inreg;
    checks++;
    if (code !== 12'h456) begin errors++; $display("FAIL midreset_next: got %h want 456", code); end
  endtask

  task automatic test_back_to_back;
    send_frame(12'h1E7, 12, 1'b0);
    send_frame(12'hC48, 12, 1'b0);
    pulse_ld();
    m_code = m_inreg;
    checks++;
    if (code !== 12'hC48) begin errors++; $display("FAIL b2b_code: got %h want c48", code); end
  endtask

  task automatic test_random;
    logic [11:0] d;
    int nb, cv0, fe0, exp_fe;
    bit mid, do_ld;
    for (int f = 0; f < 24; f++) begin
      d     = 12'($urandom);
      nb    = 10 + int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) nb = 12;
      mid   = ($urandom_range(0, 4) == 0);
      do_ld = ($urandom_range(0, 2) != 0);
      fe0 = fe_cnt;
      send_frame(d, nb, mid);
      exp_fe = (nb != 12 ? 1 : 0) + (mid ? 1 : 0);
      checks++;
      if (fe_cnt - fe0 != exp_fe) begin
        errors++;
        $display("FAIL rand_fe[%0d]: got %0d want %0d (nbits=%0d)", f, fe_cnt - fe0, exp_fe, nb);
      end
      checks++;
      if (code !== m_code) begin errors++; $display("FAIL rand_hold[%0d]: got %h want %h", f, code, m_code); end
      if (do_ld) begin
        cv0 = cv_cnt;
        pulse_ld();
        m_code = m_inreg;
        checks++;
        if (code !== m_code || cv_cnt - cv0 != 1) begin
          errors++;
          $display("FAIL rand_load[%0d]: got %h/%0d want %h/1", f, code, cv_cnt - cv0, m_code);
        end
      end
    end
  endtask

`ifdef DAC7611_RX_ERRCNT_EN
  task automatic test_errcnt;
    do_reset();
    for (int f = 0; f < 300; f++) begin
      dac_cs = 1'b0;
      wait_cyc(HC);
      dac_cs = 1'b1;
      wait_cyc(HC);
      if (f == 9) begin
        wait_cyc(2);
        checks++;
        if (err_count !== 8'd10) begin errors++; $display("FAIL errcnt_10: got %0d want 10", err_count); end
      end
    end
    wait_cyc(4);
    checks++;
    if (err_count !== 8'd255) begin errors++; $display("FAIL errcnt_sat: got %0d want 255", err_count); end
    do_reset();
    checks++;
    if (err_count !== 8'd0) begin errors++; $display("FAIL errcnt_reset: got %0d want 0", err_count); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    idle_pins();
    test_reset();
    test_load_latency();
    test_short_frame();
    test_clear();
    test_reset_midframe();
    test_back_to_back();
    test_random();
`ifdef DAC7611_RX_ERRCNT_EN
    test_errcnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac7611_rx.md
DAC7611_RX -- requirements
Module: dac7611_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of input synchroniser flops per pin (legal 2..4).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port dac_cs  input  1  serial chip select, active low.
REQ-005 SHALL have port dac_clk  input  1  serial clock; data captured on its rising edge.
REQ-006 SHALL have port dac_sdi  input  1  serial data, MSB first.
REQ-007 SHALL have port dac_ld  input  1  load strobe, active low; transfers input register to output latch.
REQ-008 SHALL have port dac_clr  input  1  clear, active low; forces output latch to zero.
REQ-009 SHALL have port code  output  12  current DAC latch value (models analogue output code).
REQ-010 SHALL have port code_valid  output  1  one-cycle pulse when code changes due to LD or CLR.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse on a malformed frame.
REQ-012 SHALL have port busy  output  1  high while a frame is being shifted (state SHIFT).

Function
REQ-013 SHALL pass all five dac_* inputs through SYNC_STAGES flops before use; no other logic touches raw pins.
REQ-014 SHALL detect synchronised dac_clk rising edge (prev 0, now 1) and dac_ld falling edge (prev 1, now 0) with one extra register stage.
REQ-015 SHALL implement states IDLE, SHIFT, HOLD.
REQ-016 IDLE -> SHIFT when synchronised dac_cs is low; clears 4-bit bit counter and 12-bit shift register.
REQ-017 In SHIFT, each dac_clk rising edge with cs low SHALL shift dac_sdi in at LSB (shreg <= {shreg[10:0], sdi}) and increment counter, saturating at 15.
REQ-018 SHIFT -> HOLD on cs rising when counter == 12; shreg copied to 12-bit input register.
REQ-019 SHIFT -> IDLE on cs rising when counter != 12; frame_err pulses one cycle; input register unchanged.
REQ-020 HOLD: ld falling edge SHALL copy input register to code, pulse code_valid, go IDLE; cs falling edge in HOLD -> SHIFT (new frame), held value stays in input register.
REQ-021 ld falling edge in IDLE SHALL reload code from input register (repeat load permitted) and pulse code_valid.
REQ-022 ld falling edge in SHIFT SHALL be ignored and pulse frame_err.
REQ-023 dac_clk edges while cs high SHALL be ignored.
REQ-024 Synchronised dac_clr low SHALL force code and input register to 0 each cycle it is low, pulse code_valid once on its falling edge, and override any simultaneous ld load.
REQ-025 Latency: pin-level ld fall to code/code_valid update SHALL be SYNC_STAGES+1 clk cycles.
REQ-026 Minimum dac_clk high and low time SHALL be SYNC_STAGES+1 clk periods; faster input is outside scope.

Reset
REQ-027 On reset high at a clk edge: state IDLE, code 0, input register 0, shreg 0, counter 0, code_valid 0, frame_err 0, busy 0, synchroniser flops to idle levels (cs/ld/clr 1, clk/sdi 0).
REQ-028 Reset mid-frame SHALL discard the partial frame with no frame_err pulse.

Configuration
REQ-029 With macro DAC7611_RX_ERRCNT_EN defined, SHALL add output port err_count (8 bits) counting frame_err pulses, saturating at 255, cleared by reset.
REQ-030 Without DAC7611_RX_ERRCNT_EN, err_count port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-031 Reset, then idle inputs 20 cycles -> code 0x000, no code_valid, no frame_err.
REQ-032 Frame 0xA5C (12 clocks), cs high, ld pulse -> code 0xA5C, single code_valid SYNC_STAGES+1 cycles after ld fall.
REQ-033 Frame of 11 clocks then cs high -> frame_err pulse; following ld pulse reloads previous code unchanged.
REQ-034 Frame 0xFFF loaded, then clr low 4 cycles -> code 0x000, one code_valid; ld asserted with clr low -> code stays 0x000.
REQ-035 Reset asserted after 6 bits of frame 0x123 -> state IDLE, code 0x000, no frame_err; next full frame 0x456 + ld -> code 0x456.
REQ-036 With DAC7611_RX_ERRCNT_EN: 300 short frames -> err_count 255 saturated; reset -> 0.
